pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard controller for the 5-stage pipeline: IF, ID, EX, MEM, WB.
- Keeps its own shadow of in-flight destination tags for the EX, MEM and WB slots.
- From those tags it drives PC/IF-ID write enables, bubble insertion into EX, IF-ID flush on taken branch, and operand forwarding selects for the instruction in ID.
- Freezes the whole pipeline while data memory reports busy, with a watchdog on long waits.

Parameters:
- REG_AW, 5, register index width
- MAX_WAIT, 64, mem_busy cycles before mem_timeout sets
- CNT_W, 16, width of wait and performance counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- id_rs  in  REG_AW  ID source register A
- id_rt  in  REG_AW  ID source register B
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_rd  in  REG_AW  ID destination register
- id_wr  in  1  ID instruction writes id_rd
- id_load  in  1  ID instruction is a load
- ex_br_taken  in  1  branch in EX resolved taken
- mem_busy  in  1  data memory not ready; freeze request
- pc_we  out  1  PC update enable
- fd_we  out  1  IF/ID latch enable
- fd_flush  out  1  clear IF/ID to NOP
- dx_bubble  out  1  load NOP into ID/EX instead of ID output
- fwd_a  out  2  operand A source: 00 regfile, 01 EX result, 10 MEM result (load data if load), 11 WB value
- fwd_b  out  2  same encoding for operand B
- mem_timeout  out  1  sticky watchdog error

Behaviour:
- Shadow slots EX, MEM and WB each hold {valid, rd, load}. All are invalid at reset.
- A slot matches a source register when it is valid, its rd is nonzero, rd equals the source, and the corresponding id_use bit is set.
- FSM states:
  - RUN → MWAIT when mem_busy=1.
  - MWAIT → RUN on the first cycle mem_busy=0.
  - Reset state: RUN.
- Freeze (mem_busy=1, either state):
  - pc_we=0, fd_we=0, fd_flush=0, dx_bubble=0.
  - Slots hold their values.
  - Wait counter increments, saturating at its maximum.
  - ex_br_taken is ignored; its source is frozen, so it re-presents when the freeze ends.
- Wait counter clears on return to RUN.
- mem_timeout sets when the wait counter reaches MAX_WAIT. It clears only on reset.
- Priority when mem_busy=0: branch > load-use > normal.
- Branch (ex_br_taken=1):
  - pc_we=1, fd_we=1, fd_flush=1, dx_bubble=1.
  - Slots shift (WB<=MEM, MEM<=EX) and EX<=invalid.
  - Penalty is 2 slots. A coincident load-use condition is discarded because the ID instruction is killed.
- Load-use (EX slot is a load and matches a source):
  - pc_we=0, fd_we=0, dx_bubble=1.
  - Slots shift and EX<=invalid, giving exactly one stall cycle.
  - The following cycle forwards with code 10.
- Normal:
  - pc_we=1, fd_we=1, fd_flush=0, dx_bubble=0.
  - Slots shift and EX<={id_wr, id_rd, id_load}.
- Forwarding (combinational, evaluated per operand, nearest slot wins): EX match (non-load) = 01, else MEM match = 10, else WB match = 11, else 00.
- Forwarding outputs are don't-care during freeze or a bubble.
- Register 0 never forwards and never stalls.
- Reset (async, mid-operation included):
  - Slots invalid, state RUN, counters 0, mem_timeout=0.
  - Outputs settle to pc_we=1, fd_we=1, fd_flush=0, dx_bubble=0, fwd_a=fwd_b=00.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_stall, perf_flush and perf_freeze, each CNT_W wide and saturating. They count load-use stall cycles, branch flush cycles and mem_busy cycles respectively. All reset to 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- ADD r3 in ID then next ID reads r3 (use_rs=1) → fwd_a=01, no stall; one cycle later the following reader of r3 gets fwd_a=10, then 11.
- LOAD r5 in EX slot, ID reads r5 via rt → one cycle of pc_we=0, fd_we=0, dx_bubble=1; next cycle fwd_b=10, pc_we=1.
- ex_br_taken=1 together with a load-use condition → fd_flush=1, dx_bubble=1, pc_we=1 for one cycle; no stall cycle follows.
- mem_busy high for 3 cycles during a branch → pc_we=fd_we=0 and no flush for 3 cycles; the flush occurs on the 4th cycle; slots unchanged across the freeze.
- mem_busy held for 64 cycles (MAX_WAIT=64) → mem_timeout=1 on the 64th cycle and stays 1 after mem_busy drops, until rst=0.
- Writes and reads of r0 everywhere → fwd=00, never a stall; rst pulled low mid-stall → outputs return to reset values immediately and all slots are invalid.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : hazard controller for a 5-stage pipeline (stall, bubble, flush, forward, freeze).
// Latency : control and forwarding outputs are combinational from the ID inputs and the shadow slots.
//           Slot, FSM and counter state updates on the next clk edge.
// Backpress: mem_busy freezes the whole pipeline (all enables low, slots held). A watchdog sets
//           the sticky mem_timeout flag after MAX_WAIT consecutive busy cycles.
// Ports   : clk/rst (async active-low); id_* describe the instruction in ID; ex_br_taken, mem_busy;
//           pc_we, fd_we, fd_flush, dx_bubble, fwd_a, fwd_b, mem_timeout.
// Option  : define HAZARD_PERF_CNT_EN to add the saturating counters perf_stall, perf_flush and perf_freeze.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              ex_br_taken,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              fd_we,
    output logic              fd_flush,
    output logic              dx_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_flush,
    output logic [CNT_W-1:0]  perf_freeze
`endif
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              load;
    } slot_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_q, state_d;
    slot_t              ex_q, ex_d;
    slot_t              mem_q, mem_d;
    slot_t              wb_q, wb_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;

    // A slot only produces a hazard for an operand the ID instruction actually reads;
    // register 0 is hard-wired and therefore never matches.
    function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] src,
                                        input logic use_src);
        return s.vld && (s.rd != '0) && (s.rd == src) && use_src;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic ex_a, mem_a, wb_a;
    logic ex_b, mem_b, wb_b;
    logic load_use;

    always_comb begin
        ex_a     = slot_match(ex_q,  id_rs, id_use_rs);
        mem_a    = slot_match(mem_q, id_rs, id_use_rs);
        wb_a     = slot_match(wb_q,  id_rs, id_use_rs);
        ex_b     = slot_match(ex_q,  id_rt, id_use_rt);
        mem_b    = slot_match(mem_q, id_rt, id_use_rt);
        wb_b     = slot_match(wb_q,  id_rt, id_use_rt);
        load_use = ex_q.load && (ex_a || ex_b);
    end

    // Nearest producer wins. A load in EX cannot forward; that case is covered by the
    // load-use stall, so falling through to older slots is harmless.
    always_comb begin
        fwd_a = 2'b00;
        if (ex_a && !ex_q.load) fwd_a = 2'b01;
        else if (mem_a)         fwd_a = 2'b10;
        else if (wb_a)          fwd_a = 2'b11;

        fwd_b = 2'b00;
        if (ex_b && !ex_q.load) fwd_b = 2'b01;
        else if (mem_b)         fwd_b = 2'b10;
        else if (wb_b)          fwd_b = 2'b11;
    end

    always_comb begin
        state_d    = state_q;
        ex_d       = ex_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        wait_cnt_d = wait_cnt_q;
        pc_we      = 1'b1;
        fd_we      = 1'b1;
        fd_flush   = 1'b0;
        dx_bubble  = 1'b0;

        if (mem_busy) begin
            // Freeze: nothing advances, and the branch resolution is held upstream so it
            // re-presents once the memory is ready.
            state_d    = ST_MWAIT;
            pc_we      = 1'b0;
            fd_we      = 1'b0;
            wait_cnt_d = sat_inc(wait_cnt_q);
        end else begin
            state_d = ST_RUN;
            if (state_q == ST_MWAIT) begin
                wait_cnt_d = '0;
            end
            wb_d  = mem_q;
            mem_d = ex_q;
            if (ex_br_taken) begin
                // The ID instruction is killed, so any load-use hazard it had is moot.
                fd_flush  = 1'b1;
                dx_bubble = 1'b1;
                ex_d      = '0;
            end else if (load_use) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_bubble = 1'b1;
                ex_d      = '0;
            end else begin
                ex_d.vld  = id_wr;
                ex_d.rd   = id_rd;
                ex_d.load = id_load;
            end
        end

        timeout_d = timeout_q || (mem_busy && (wait_cnt_d == MAX_WAIT_C));
    end

    assign mem_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q,  perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q,  perf_flush_d;
    logic [CNT_W-1:0] perf_freeze_q, perf_freeze_d;

    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_flush_d  = perf_flush_q;
        perf_freeze_d = perf_freeze_q;
        if (mem_busy) begin
            perf_freeze_d = sat_inc(perf_freeze_q);
        end else if (ex_br_taken) begin
            perf_flush_d = sat_inc(perf_flush_q);
        end else if (load_use) begin
            perf_stall_d = sat_inc(perf_stall_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
            perf_freeze_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_flush_q  <= perf_flush_d;
            perf_freeze_q <= perf_freeze_d;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_flush  = perf_flush_q;
    assign perf_freeze = perf_freeze_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl against an instruction-level pipeline model.
// Latency : outputs are checked 3 time units after each rising edge, once the inputs have settled.
// Backpress: mem_busy freeze scenarios, including the watchdog, are exercised directly.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_use_rs, id_use_rt, id_wr, id_load;
    logic       ex_br_taken, mem_busy;
    logic       pc_we, fd_we, fd_flush, dx_bubble, mem_timeout;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perf_stall, perf_flush, perf_freeze;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MAX_WAIT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush), .dx_bubble(dx_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_freeze(perf_freeze)
`endif
    );

    // Model: the instructions currently occupying EX (0), MEM (1) and WB (2).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } instr_t;

    instr_t inflight[3];
    int     busy_run;
    bit     m_to;
    int     tests;
    int     fails;

    function automatic bit reads(input instr_t s, input bit [4:0] src, input bit u);
        return u && s.v && (s.rd != 0) && (s.rd == src);
    endfunction

    function automatic bit m_lu();
        return inflight[0].ld && (reads(inflight[0], id_rs, id_use_rs) ||
                                  reads(inflight[0], id_rt, id_use_rt));
    endfunction

    // {pc_we, fd_we, fd_flush, dx_bubble}
    function automatic logic [3:0] exp_ctrl();
        if (mem_busy)    return 4'b0000;
        if (ex_br_taken) return 4'b1111;
        if (m_lu())      return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic logic [1:0] exp_fwd(input bit [4:0] src, input bit u);
        for (int k = 0; k < 3; k++) begin
            if (reads(inflight[k], src, u) && !(k == 0 && inflight[k].ld))
                return 2'(k + 1);
        end
        return 2'b00;
    endfunction

    function automatic bit fwd_care();
        return !mem_busy && !ex_br_taken && !m_lu();
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) inflight[k] = '{v: 0, rd: 0, ld: 0};
        busy_run = 0;
        m_to     = 0;
    endtask

    task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd, input logic wr,
                         input logic ld, input logic br, input logic busy);
        id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_rd = rd; id_wr = wr; id_load = ld; ex_br_taken = br; mem_busy = busy;
        #2;
    endtask

    task automatic tick();
        bit kill;
        @(posedge clk);
        if (rst) begin
            if (mem_busy) begin
                busy_run++;
                if (busy_run >= 64) m_to = 1;
            end else begin
                busy_run = 0;
                kill = ex_br_taken || m_lu();
                inflight[2] = inflight[1];
                inflight[1] = inflight[0];
                if (kill) inflight[0] = '{v: 0, rd: 0, ld: 0};
                else      inflight[0] = '{v: id_wr, rd: id_rd, ld: id_load};
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble} !== 4'b1100) begin
            fails++; $display("FAIL reset_ctrl got %b want 1100", {pc_we, fd_we, fd_flush, dx_bubble});
        end
        tests++;
        if ({fwd_a, fwd_b, mem_timeout} !== 5'b0) begin
            fails++; $display("FAIL reset_fwd got %b want 00000", {fwd_a, fwd_b, mem_timeout});
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_fwd_chain();
        drive(0, 0, 0, 0, 3, 1, 0, 0, 0);
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble} !== 4'b1100) begin
            fails++; $display("FAIL add_ctrl got %b want 1100", {pc_we, fd_we, fd_flush, dx_bubble});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(3, 1, 0, 0, 0, 0, 0, 0, 0);
            tests++;
            if (fwd_a !== 2'((i + 1) % 4)) begin
                fails++; $display("FAIL chain_fwd_a[%0d] got %b want %b", i, fwd_a, 2'((i + 1) % 4));
            end
            tests++;
            if ({pc_we, fd_we, dx_bubble} !== 3'b110) begin
                fails++; $display("FAIL chain_nostall[%0d] got %b want 110", i, {pc_we, fd_we, dx_bubble});
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        drive(0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        drive(0, 0, 5, 1, 9, 1, 0, 0, 0);
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble} !== 4'b0001) begin
            fails++; $display("FAIL lu_stall got %b want 0001", {pc_we, fd_we, fd_flush, dx_bubble});
        end
        tick();
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble, fwd_b} !== 6'b110010) begin
            fails++; $display("FAIL lu_after got %b want 110010", {pc_we, fd_we, fd_flush, dx_bubble, fwd_b});
        end
        tick();
    endtask

    task automatic test_branch_load_use();
        drive(0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        drive(0, 0, 5, 1, 9, 1, 0, 1, 0);
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble} !== 4'b1111) begin
            fails++; $display("FAIL br_lu got %b want 1111", {pc_we, fd_we, fd_flush, dx_bubble});
        end
        tick();
        drive(0, 0, 5, 1, 0, 0, 0, 0, 0);
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble, fwd_b} !== 6'b110010) begin
            fails++; $display("FAIL br_nostall got %b want 110010", {pc_we, fd_we, fd_flush, dx_bubble, fwd_b});
        end
        tick();
    endtask

    task automatic test_freeze_branch();
        drive(0, 0, 0, 0, 7, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(7, 1, 0, 0, 0, 0, 0, 1, 1);
            tests++;
            if ({pc_we, fd_we, fd_flush, dx_bubble} !== 4'b0000) begin
                fails++; $display("FAIL freeze[%0d] got %b want 0000", i, {pc_we, fd_we, fd_flush, dx_bubble});
            end
            tick();
        end
        drive(7, 1, 0, 0, 0, 0, 0, 1, 0);
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble} !== 4'b1111) begin
            fails++; $display("FAIL freeze_flush got %b want 1111", {pc_we, fd_we, fd_flush, dx_bubble});
        end
        tick();
        // r7 must have moved only one slot (into MEM) across freeze + flush.
        drive(7, 1, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (fwd_a !== 2'b10) begin
            fails++; $display("FAIL freeze_hold got %b want 10", fwd_a);
        end
        tick();
    endtask

    task automatic test_timeout();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63 || i == 64) begin
                tests++;
                if (mem_timeout !== (i == 64)) begin
                    fails++; $display("FAIL timeout_at_%0d got %b want %b", i, mem_timeout, i == 64);
                end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        tests++;
        if (mem_timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_sticky got %b want 1", mem_timeout);
        end
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (mem_timeout !== 1'b0) begin
            fails++; $display("FAIL timeout_reset got %b want 0", mem_timeout);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_r0();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 1, 0, 1, i[0], 0, 0);
            tests++;
            if ({pc_we, fd_we, fd_flush, dx_bubble, fwd_a, fwd_b} !== 8'b11000000) begin
                fails++; $display("FAIL r0[%0d] got %b want 11000000", i,
                                  {pc_we, fd_we, fd_flush, dx_bubble, fwd_a, fwd_b});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        drive(0, 0, 5, 1, 9, 1, 0, 0, 0);
        tests++;
        if (dx_bubble !== 1'b1) begin
            fails++; $display("FAIL mid_stall_pre got %b want 1", dx_bubble);
        end
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({pc_we, fd_we, fd_flush, dx_bubble, fwd_a, fwd_b} !== 8'b11000000) begin
            fails++; $display("FAIL mid_stall_rst got %b want 11000000",
                              {pc_we, fd_we, fd_flush, dx_bubble, fwd_a, fwd_b});
        end
        tick();
        rst = 1'b1;
        drive(5, 1, 5, 1, 0, 0, 0, 0, 0);
        tests++;
        if ({pc_we, fd_we, dx_bubble, fwd_a, fwd_b} !== 7'b1100000) begin
            fails++; $display("FAIL mid_stall_slots got %b want 1100000",
                              {pc_we, fd_we, dx_bubble, fwd_a, fwd_b});
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            tests++;
            if ({pc_we, fd_we, fd_flush, dx_bubble} !== exp_ctrl()) begin
                fails++; $display("FAIL rnd_ctrl[%0d] got %b want %b", i,
                                  {pc_we, fd_we, fd_flush, dx_bubble}, exp_ctrl());
            end
            if (fwd_care()) begin
                tests++;
                if ({fwd_a, fwd_b} !== {exp_fwd(id_rs, id_use_rs), exp_fwd(id_rt, id_use_rt)}) begin
                    fails++; $display("FAIL rnd_fwd[%0d] got %b want %b", i, {fwd_a, fwd_b},
                                      {exp_fwd(id_rs, id_use_rs), exp_fwd(id_rt, id_use_rt)});
                end
            end
            tests++;
            if (mem_timeout !== m_to) begin
                fails++; $display("FAIL rnd_timeout[%0d] got %b want %b", i, mem_timeout, m_to);
            end
            tick();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_fwd_chain();
        test_load_use();
        test_branch_load_use();
        test_freeze_branch();
        test_timeout();
        test_r0();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
